// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter that merges several cache refill read requesters onto one AXI read master.
// ARID carries the port index, so R beats are routed back per beat by RID.
module axi_rd_arbiter #(
    parameter int NUM_PORT  = 2,
    parameter int ID_WIDTH  = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_PORT-1:0]      req_valid,
    input  logic [NUM_PORT-1:0]      req_burst,
    input  logic [NUM_PORT*32-1:0]   req_addr,
    input  logic [NUM_PORT*2-1:0]    req_size,
    output logic [NUM_PORT-1:0]      req_ready,
    input  logic                     ar_block,
    output logic [NUM_PORT-1:0]      ret_valid,
    output logic                     ret_last,
    output logic [31:0]              ret_data,
    output logic                     ret_err,
    output logic                     rid_err,
    output logic [ID_WIDTH-1:0]      arid,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [ID_WIDTH-1:0]      rid,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready
);

    localparam int PW = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        AR_PEND = 2'd1,
        WAIT_R  = 2'd2
    } port_state_t;

    port_state_t          state [NUM_PORT];
    logic [NUM_PORT-1:0]  busy;
    logic [NUM_PORT-1:0]  eligible;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        winner;
    logic                 found;
    logic                 grant;
    logic [31:0]          sel_addr;
    logic [1:0]           sel_size;
    logic                 sel_burst;

    // Cyclic port index arithmetic; works for port counts that are not a power of two.
    function automatic logic [PW-1:0] port_add(input logic [PW-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_PORT)
            sum = sum - NUM_PORT;
        return PW'(sum);
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORT; p++)
            busy[p] = (state[p] != IDLE);
    end

    assign eligible = req_valid & ~busy;

    always_comb begin
        logic [PW-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            idx = port_add(rr_ptr, i);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // A new AR may only be loaded when the register is empty or draining this cycle.
    assign grant = ~reset & ~ar_block & (~arvalid | arready) & found;

    always_comb begin
        req_ready = '0;
        if (grant)
            req_ready[winner] = 1'b1;
    end

    always_comb begin
        sel_addr  = '0;
        sel_size  = '0;
        sel_burst = 1'b0;
        for (int p = 0; p < NUM_PORT; p++) begin
            if (winner == PW'(p)) begin
                sel_addr  = req_addr[32*p +: 32];
                sel_size  = req_size[2*p +: 2];
                sel_burst = req_burst[p];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORT; p++)
            ret_valid[p] = rvalid & (rid == ID_WIDTH'(p)) & busy[p];
    end

    assign ret_last = rlast;
    assign ret_data = rdata;
    assign ret_err  = rvalid & (rresp != 2'b00);
    assign rready   = 1'b1;
    assign arlock   = 1'b0;
    assign arcache  = 4'b0000;
    assign arprot   = 3'b000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arvalid <= 1'b0;
            araddr  <= '0;
            arid    <= '0;
            arlen   <= '0;
            arsize  <= '0;
            arburst <= '0;
            rr_ptr  <= '0;
            rid_err <= 1'b0;
            for (int p = 0; p < NUM_PORT; p++)
                state[p] <= IDLE;
        end else begin
            if (grant) begin
                arvalid <= 1'b1;
                araddr  <= sel_addr;
                arid    <= ID_WIDTH'(winner);
                rr_ptr  <= port_add(winner, 1);
                if (sel_burst) begin
                    arlen   <= 8'(BURST_LEN - 1);
                    arsize  <= 3'b010;
                    arburst <= 2'b01;
                end else begin
                    arlen   <= 8'd0;
                    arsize  <= {1'b0, sel_size};
                    arburst <= 2'b00;
                end
            end else if (arready) begin
                arvalid <= 1'b0;
            end

            // Beats for an out-of-range or idle ID are dropped and flagged until reset.
            if (rvalid && (ret_valid == '0))
                rid_err <= 1'b1;

            for (int p = 0; p < NUM_PORT; p++) begin
                case (state[p])
                    IDLE:
                        if (grant && (winner == PW'(p)))
                            state[p] <= AR_PEND;
                    AR_PEND:
                        if (arvalid && arready && (arid == ID_WIDTH'(p)))
                            state[p] <= WAIT_R;
                    WAIT_R:
                        if (ret_valid[p] && rlast)
                            state[p] <= IDLE;
                    default:
                        state[p] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: AR transactions are checked against a scoreboard queue,
// R routing, grant order, blocking and reset behaviour are checked inline.
module tb_axi_rd_arbiter;

    localparam int NP = 2;
    localparam int IW = 4;
    localparam int BL = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     req_valid, req_burst, req_ready, ret_valid;
    logic [NP*32-1:0]  req_addr;
    logic [NP*2-1:0]   req_size;
    logic              ar_block, ret_last, ret_err, rid_err;
    logic [31:0]       ret_data, araddr, rdata;
    logic [IW-1:0]     arid, rid;
    logic [7:0]        arlen;
    logic [2:0]        arsize, arprot;
    logic [1:0]        arburst, rresp;
    logic              arlock, arvalid, arready, rlast, rvalid, rready;
    logic [3:0]        arcache;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    ar_t sb[$];
    ar_t exp_ar;
    int  checks = 0;
    int  errors = 0;

    axi_rd_arbiter #(.NUM_PORT(NP), .ID_WIDTH(IW), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_burst(req_burst), .req_addr(req_addr), .req_size(req_size),
        .req_ready(req_ready), .ar_block(ar_block),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data), .ret_err(ret_err),
        .rid_err(rid_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ar_t mk(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                               input logic [2:0] s, input logic [1:0] b);
        ar_t t;
        t.id = id; t.addr = a; t.len = l; t.size = s; t.burst = b;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // AR handshakes are popped from the scoreboard and compared field by field.
    always @(negedge clk) begin
        if (reset === 1'b0 && arvalid === 1'b1 && arready === 1'b1) begin
            if (sb.size() == 0) begin
                check("ar_unexpected", 64'd1, 64'd0);
            end else begin
                exp_ar = sb.pop_front();
                check("ar_id", arid, exp_ar.id);
                check("ar_addr", araddr, exp_ar.addr);
                check("ar_len", arlen, exp_ar.len);
                check("ar_size", arsize, exp_ar.size);
                check("ar_burst", arburst, exp_ar.burst);
                check("ar_const", {arlock, arcache, arprot}, 8'd0);
            end
        end
    end

    initial begin
        reset = 1'b1; req_valid = '0; req_burst = '0; req_addr = '0; req_size = '0;
        ar_block = 1'b0; arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
        rvalid = 1'b0;
        repeat (2) tick();
        at_neg();
        check("rst_arvalid", arvalid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_ret_valid", ret_valid, 0);
        check("rst_rid_err", rid_err, 0);
        check("rst_araddr", araddr, 0);
        check("rready", rready, 1);
        tick();
        reset = 1'b0;

        // Port 0 line burst, AR stalled one cycle, then four R beats
        req_valid = 2'b01; req_burst = 2'b01; req_addr[31:0] = 32'h1C00_0010;
        at_neg();
        check("t3_req_ready", req_ready, 2'b01);
        sb.push_back(mk(4'd0, 32'h1C00_0010, 8'd3, 3'd2, 2'd1));
        tick();
        req_valid = 2'b00;
        at_neg();
        check("t3_arvalid", arvalid, 1);
        check("t3_arid", arid, 0);
        tick();
        arready = 1'b1;
        at_neg();
        tick();
        arready = 1'b0;
        at_neg();
        check("t3_ar_drained", arvalid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            rvalid = 1'b1; rid = 4'd0; rdata = 32'hA000_0000 + i; rlast = (i == 3);
            at_neg();
            check("t3_ret_valid", ret_valid, 2'b01);
            check("t3_ret_last", ret_last, (i == 3));
            check("t3_ret_data", ret_data, 32'hA000_0000 + i);
        end
        tick();
        rvalid = 1'b0; rlast = 1'b0;

        // Port 1 single byte; AR held 5 cycles with another request pending
        req_valid = 2'b10; req_burst = 2'b00; req_addr[63:32] = 32'h2000_0003; req_size[3:2] = 2'd0;
        at_neg();
        check("t4_req_ready", req_ready, 2'b10);
        sb.push_back(mk(4'd1, 32'h2000_0003, 8'd0, 3'd0, 2'd0));
        tick();
        req_valid = 2'b11; req_burst = 2'b01; req_addr[31:0] = 32'h3000_0040;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            check("t4_hold_arvalid", arvalid, 1);
            check("t4_hold_araddr", araddr, 32'h2000_0003);
            check("t4_hold_arid", arid, 1);
            check("t4_no_grant", req_ready, 2'b00);
            tick();
        end
        req_valid = 2'b00; arready = 1'b1;
        at_neg();
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd1; rlast = 1'b1; rresp = 2'b10; rdata = 32'h0000_00AB;
        at_neg();
        check("t4_ret_valid", ret_valid, 2'b10);
        check("t4_ret_err", ret_err, 1);
        check("t4_ret_last", ret_last, 1);
        check("t4_ret_data", ret_data, 32'h0000_00AB);
        check("t4_arvalid_low", arvalid, 0);
        tick();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;

        // Both ports request every cycle: grants 0 then 1, no re-grant while busy
        req_valid = 2'b11; req_burst = 2'b11;
        req_addr[31:0] = 32'h4000_0000; req_addr[63:32] = 32'h5000_0000; arready = 1'b1;
        at_neg();
        check("t2_grant0", req_ready, 2'b01);
        sb.push_back(mk(4'd0, 32'h4000_0000, 8'd3, 3'd2, 2'd1));
        tick();
        at_neg();
        check("t2_grant1", req_ready, 2'b10);
        sb.push_back(mk(4'd1, 32'h5000_0000, 8'd3, 3'd2, 2'd1));
        tick();
        at_neg();
        check("t2_no_regrant", req_ready, 2'b00);
        check("t2_b2b_arvalid", arvalid, 1);
        tick();
        at_neg();
        check("t2_idle_arvalid", arvalid, 0);
        check("t2_still_busy", req_ready, 2'b00);
        tick();

        // Interleaved R beats; port 1 finishes first and is re-granted before port 0
        req_valid = 2'b01;
        rvalid = 1'b1; rid = 4'd1; rlast = 1'b0; rdata = 32'h1111_0001;
        at_neg();
        check("t5_b0_route", ret_valid, 2'b10);
        check("t5_b0_ready", req_ready, 2'b00);
        tick();
        rid = 4'd0; rdata = 32'h0000_0001;
        at_neg();
        check("t5_b1_route", ret_valid, 2'b01);
        check("t5_b1_ready", req_ready, 2'b00);
        tick();
        rid = 4'd1; rlast = 1'b1;
        at_neg();
        check("t5_b2_route", ret_valid, 2'b10);
        check("t5_b2_last", ret_last, 1);
        tick();
        rid = 4'd0; rlast = 1'b1;
        req_valid = 2'b11; req_burst = 2'b00; req_addr[63:32] = 32'h6000_0008; req_size[3:2] = 2'd2;
        at_neg();
        check("t5_b3_route", ret_valid, 2'b01);
        check("t5_port1_free_first", req_ready, 2'b10);
        sb.push_back(mk(4'd1, 32'h6000_0008, 8'd0, 3'd2, 2'd0));
        tick();
        rvalid = 1'b0; rlast = 1'b0; req_valid = 2'b00;
        at_neg();
        check("t5_no_req", req_ready, 2'b00);
        tick();

        // Unknown and idle RID beats, then ar_block holding off a grant
        rvalid = 1'b1; rid = 4'd3; rlast = 1'b1;
        at_neg();
        check("t6_bad_rid_route", ret_valid, 2'b00);
        check("t6_err_before", rid_err, 0);
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        at_neg();
        check("t6_rid_err_set", rid_err, 1);
        tick();
        rvalid = 1'b1; rid = 4'd0;
        at_neg();
        check("t6_idle_rid_route", ret_valid, 2'b00);
        tick();
        rvalid = 1'b0;
        ar_block = 1'b1; req_valid = 2'b01; req_burst = 2'b01; req_addr[31:0] = 32'h7000_0000;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            check("t6_block_ready", req_ready, 2'b00);
            check("t6_block_arvalid", arvalid, 0);
            check("t6_rid_err_sticky", rid_err, 1);
            tick();
        end
        ar_block = 1'b0;
        at_neg();
        check("t6_unblock_ready", req_ready, 2'b01);
        sb.push_back(mk(4'd0, 32'h7000_0000, 8'd3, 3'd2, 2'd1));
        tick();
        req_valid = 2'b00;
        at_neg();
        tick();
        rvalid = 1'b1; rid = 4'd1; rlast = 1'b1;
        at_neg();
        check("t6_p1_close", ret_valid, 2'b10);
        tick();
        rid = 4'd0;
        at_neg();
        check("t6_p0_close", ret_valid, 2'b01);
        tick();
        rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;

        // Reset while an AR is pending
        req_valid = 2'b01; req_burst = 2'b01; req_addr[31:0] = 32'h8000_0000;
        at_neg();
        check("t1_req_ready", req_ready, 2'b01);
        sb.push_back(mk(4'd0, 32'h8000_0000, 8'd3, 3'd2, 2'd1));
        tick();
        req_valid = 2'b11;
        at_neg();
        check("t1_arvalid_pending", arvalid, 1);
        tick();
        reset = 1'b1; rvalid = 1'b1; rid = 4'd0;
        #1;
        check("t1_rst_arvalid", arvalid, 0);
        check("t1_rst_req_ready", req_ready, 2'b00);
        check("t1_rst_rid_err", rid_err, 0);
        check("t1_rst_ret_valid", ret_valid, 2'b00);
        check("t1_rst_araddr", araddr, 0);
        sb.delete();
        tick();
        reset = 1'b0; rvalid = 1'b0; req_valid = 2'b00;
        at_neg();
        check("t1_post_arvalid", arvalid, 0);
        tick();
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
